oam_dma: RTL and testbench



---
 rtl/oam_dma.sv | 114 +++++++++++
 tb/tb_oam_dma.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// Sprite DMA engine: snoops CPU writes to the DMA page register, halts the CPU,
// and copies one 256-byte CPU page to the PPU OAM data port as read/write pairs.
module oam_dma #(
    parameter int                    ADDR_WIDTH    = 16,
    parameter int                    REG_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [REG_WIDTH-1:0]  cpu_data,
    input  logic                  cpu_we,
    input  logic [REG_WIDTH-1:0]  mem_data_in,
    output logic                  rdy,
    output logic                  bus_req,
    output logic [ADDR_WIDTH-1:0] dma_addr,
    output logic [REG_WIDTH-1:0]  dma_data_out,
    output logic                  dma_we,
    output logic                  busy
);

    // state | meaning
    // IDLE  | CPU owns the bus, waiting for a page-register write
    // HALT  | rdy dropped, CPU finishing its current cycle
    // ALIGN | extra wait so the first read lands on even parity
    // READ  | DMA reads {page, idx} from memory
    // WRITE | DMA writes the latched byte to the OAM data port
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [REG_WIDTH-1:0] page;
    logic [7:0]           idx;
    logic [REG_WIDTH-1:0] latch;
    logic                 par;
    logic                 trigger;

    assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = HALT;
            HALT:    state_next = par ? ALIGN : READ;
            ALIGN:   state_next = READ;
            READ:    state_next = WRITE;
            WRITE:   state_next = (idx == 8'hFF) ? IDLE : READ;
            default: state_next = IDLE;
        endcase
    end

    // idx wraps within 8 bits and never carries into page
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            page  <= '0;
            idx   <= '0;
            latch <= '0;
            par   <= 1'b0;
        end else begin
            par <= ~par;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page <= cpu_data;
                        idx  <= '0;
                    end
                end
                READ:  latch <= mem_data_in;
                WRITE: if (idx != 8'hFF) idx <= idx + 8'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdy          = 1'b0;
        bus_req      = 1'b0;
        dma_we       = 1'b0;
        dma_addr     = '0;
        dma_data_out = '0;
        case (state)
            IDLE: rdy = 1'b1;
            READ: begin
                bus_req  = 1'b1;
                dma_addr = ADDR_WIDTH'({page, idx});
            end
            WRITE: begin
                bus_req      = 1'b1;
                dma_we       = 1'b1;
                dma_addr     = OAM_DATA_ADDR;
                dma_data_out = latch;
            end
            default: ;
        endcase
    end

    assign busy = ~rdy;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: randomized memory and trigger timing,
// compared against a transaction-level model of the 256-byte page copy.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_we;
    logic [7:0]  mem_data_in;
    logic        rdy;
    logic        bus_req;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_out;
    logic        dma_we;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem [0:65535];
    logic        par_m;
    logic [15:0] rd_q[$];
    logic [7:0]  wr_q[$];
    int          low_cnt;
    int          first_read_cyc;
    int          bad_write_addr;
    logic        halt_par;
    logic        timeout;

    oam_dma dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .cpu_we       (cpu_we),
        .mem_data_in  (mem_data_in),
        .rdy          (rdy),
        .bus_req      (bus_req),
        .dma_addr     (dma_addr),
        .dma_data_out (dma_data_out),
        .dma_we       (dma_we),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // reference parity: free-running toggle, cleared by reset
    always @(posedge clk or posedge reset) begin
        if (reset) par_m <= 1'b0;
        else       par_m <= ~par_m;
    end

    assign mem_data_in = mem[dma_addr];

    // want_par: 0/1 forces HALT parity, anything else takes whatever comes
    task automatic start_trigger(input logic [7:0] pg, input int want_par, input bit immediate);
        if (!immediate) @(negedge clk);
        if (want_par == 0 || want_par == 1) begin
            while ((~par_m) !== want_par[0]) @(negedge clk);
        end
        cpu_addr = 16'h4014;
        cpu_data = pg;
        cpu_we   = 1'b1;
        @(negedge clk);
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_data = 8'h00;
    endtask

    // called at the negedge inside the HALT cycle; returns at first rdy=1 cycle
    task automatic observe(input int retrig_at, input logic [7:0] retrig_pg);
        rd_q.delete();
        wr_q.delete();
        low_cnt        = 0;
        first_read_cyc = -1;
        bad_write_addr = 0;
        halt_par       = par_m;
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (rdy === 1'b1) break;
            low_cnt++;
            if (bus_req === 1'b1 && dma_we === 1'b0) begin
                if (first_read_cyc < 0) first_read_cyc = cyc;
                rd_q.push_back(dma_addr);
            end
            if (dma_we === 1'b1) begin
                if (dma_addr !== 16'h2004) bad_write_addr++;
                wr_q.push_back(dma_data_out);
            end
            if (cyc == retrig_at) begin
                cpu_addr = 16'h4014;
                cpu_data = retrig_pg;
                cpu_we   = 1'b1;
            end else begin
                cpu_we   = 1'b0;
                cpu_addr = 16'h0000;
            end
            @(negedge clk);
        end
        cpu_we  = 1'b0;
        timeout = (rdy !== 1'b1);
    endtask

    function automatic int rd_errs(input logic [7:0] pg);
        int e = 0;
        if (rd_q.size() != 256) return 1000 + rd_q.size();
        for (int i = 0; i < 256; i++)
            if (rd_q[i] !== {pg, 8'(i)}) e++;
        return e;
    endfunction

    function automatic int wr_errs(input logic [7:0] pg);
        int e = 0;
        if (wr_q.size() != 256) return 1000 + wr_q.size();
        for (int i = 0; i < 256; i++)
            if (wr_q[i] !== mem[{pg, 8'(i)}]) e++;
        return e;
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if ({rdy, busy, bus_req, dma_we} !== 4'b1000 || dma_addr !== 16'h0 || dma_data_out !== 8'h0) begin
            failures++;
            $display("FAIL reset_outputs got rdy/busy/req/we=%b addr=%h data=%h exp 1000/0000/00",
                     {rdy, busy, bus_req, dma_we}, dma_addr, dma_data_out);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy !== 1'b1 || bus_req !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got rdy=%b bus_req=%b exp rdy=1 bus_req=0", rdy, bus_req);
        end
    endtask

    task automatic test_transfer(input string name, input logic [7:0] pg, input int want_par,
                                 input int retrig_at, input bit immediate);
        int exp_low;
        start_trigger(pg, want_par, immediate);
        observe(retrig_at, 8'h05);
        exp_low = halt_par ? 514 : 513;
        checks++;
        if (timeout || low_cnt != exp_low) begin
            failures++;
            $display("FAIL %s_stall got=%0d exp=%0d timeout=%0b", name, low_cnt, exp_low, timeout);
        end
        checks++;
        if (first_read_cyc != (halt_par ? 2 : 1)) begin
            failures++;
            $display("FAIL %s_first_read got=%0d exp=%0d", name, first_read_cyc, halt_par ? 2 : 1);
        end
        checks++;
        if (rd_errs(pg) != 0) begin
            failures++;
            $display("FAIL %s_reads got=%0d bad exp=0 (page %h)", name, rd_errs(pg), pg);
        end
        checks++;
        if (wr_errs(pg) != 0 || bad_write_addr != 0) begin
            failures++;
            $display("FAIL %s_writes got=%0d bad data, %0d bad addr exp=0", name, wr_errs(pg), bad_write_addr);
        end
    endtask

    task automatic test_even();
        for (int a = 16'h0200; a <= 16'h02FF; a++) mem[a] = ~a[7:0];
        test_transfer("even", 8'h02, 0, -1, 1'b0);
        checks++;
        if (wr_q.size() != 256 || wr_q[0] !== 8'hFF || wr_q[255] !== 8'h00) begin
            failures++;
            $display("FAIL even_pattern got first=%h last=%h exp FF/00",
                     wr_q.size() > 0 ? wr_q[0] : 8'hxx, wr_q.size() > 255 ? wr_q[255] : 8'hxx);
        end
    endtask

    task automatic test_odd();
        test_transfer("odd", 8'($urandom_range(0, 254)), 1, -1, 1'b0);
    endtask

    task automatic test_retrigger();
        test_transfer("retrig", 8'h02, 2, $urandom_range(5, 500), 1'b0);
    endtask

    task automatic test_page_ff();
        int zero_hits = 0;
        test_transfer("page_ff", 8'hFF, 2, -1, 1'b0);
        foreach (rd_q[i]) if (rd_q[i] === 16'h0000) zero_hits++;
        checks++;
        if (zero_hits != 0) begin
            failures++;
            $display("FAIL page_ff_wrap got=%0d reads of 0000 exp=0", zero_hits);
        end
    endtask

    task automatic test_back_to_back();
        test_transfer("b2b_first", 8'($urandom_range(0, 255)), 2, -1, 1'b0);
        test_transfer("b2b_second", 8'($urandom_range(0, 255)), 2, -1, 1'b1);
    endtask

    task automatic test_reset_mid();
        int writes = 0;
        int bad = 0;
        start_trigger(8'h37, 2, 1'b0);
        for (int cyc = 0; cyc < 400 && writes < 64; cyc++) begin
            if (dma_we === 1'b1) writes++;
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({rdy, busy, bus_req, dma_we} !== 4'b1000 || dma_addr !== 16'h0 || dma_data_out !== 8'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs got rdy/busy/req/we=%b addr=%h data=%h exp 1000/0000/00",
                     {rdy, busy, bus_req, dma_we}, dma_addr, dma_data_out);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rdy !== 1'b1 || bus_req !== 1'b0 || dma_we !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0 || writes != 64) begin
            failures++;
            $display("FAIL reset_mid_no_resume got=%0d busy cycles (writes seen %0d) exp=0 (64)", bad, writes);
        end
        test_transfer("after_reset", 8'h37, 2, -1, 1'b0);
    endtask

    task automatic test_non_trigger();
        int bad = 0;
        logic [15:0] addrs [3] = '{16'h4014, 16'h4015, 16'h2004};
        logic        wes   [3] = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cpu_addr = addrs[k];
            cpu_data = 8'($urandom);
            cpu_we   = wes[k];
            @(negedge clk);
            cpu_we = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (rdy !== 1'b1 || bus_req !== 1'b0) bad++;
                @(negedge clk);
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL non_trigger got=%0d stalled cycles exp=0", bad);
        end
    endtask

    initial begin
        reset    = 1'b1;
        cpu_addr = 16'h0000;
        cpu_data = 8'h00;
        cpu_we   = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        test_reset();
        test_even();
        test_odd();
        test_retrigger();
        test_non_trigger();
        test_reset_mid();
        test_page_ff();
        test_back_to_back();
        for (int r = 0; r < 2; r++) test_transfer("random", 8'($urandom), 2, -1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
